// File: rtl/uart_rx_byte.sv
// uart_rx_byte: 8N1 serial receiver with centre sampling.
// The line is resynchronised into the clock domain first. A baud counter then
// times the start-bit midpoint and every following bit centre. Good bytes are
// presented with a one-cycle rx_done strobe. A low stop bit gives a one-cycle
// frame_err strobe, and the receiver then waits for the line to return high.
module uart_rx_byte #(
    parameter int CLK_FREQ = 100_000_000,
    parameter int BAUD     = 115_200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_done,
    output logic       frame_err,
    output logic       busy
);

    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam int HALF         = (CLKS_PER_BIT - 1) / 2;
    localparam int CNT_W        = $clog2(CLKS_PER_BIT);

    localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'(HALF);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(CLKS_PER_BIT - 1);

    // Below four clocks per bit there is no usable centre sample.
    generate
        if (CLKS_PER_BIT < 4) begin : g_bad_baud
            $error("uart_rx_byte: CLK_FREQ/BAUD must be at least 4");
        end
    endgenerate

    typedef enum logic [2:0] {
        S_WAIT_IDLE,
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    state_t           r_state;
    state_t           w_next_state;
    logic             r_sync1;
    logic             r_sync2;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_bit_idx;
    logic [7:0]       r_shift;
    logic [7:0]       r_rx_data;
    logic             r_rx_done;
    logic             r_frame_err;

    logic             w_rx_s;
    logic             w_counting;
    logic             w_tick;
    logic             w_shift_en;
    logic             w_load;
    logic             w_err;

    assign w_rx_s = r_sync2;

    // Two-flop synchroniser. Both flops reset to the idle line level so a
    // reset never looks like a start bit.
    // NOTE: all clocked state uses non-blocking assignments, so every flop
    // samples the values from before the edge and block order does not matter.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= rx;
            r_sync2 <= r_sync1;
        end
    end

    // The counter only runs while a frame is in progress. Its terminal value
    // is half a bit in START, which lands every later sample at a bit centre.
    assign w_counting = (r_state == S_START) || (r_state == S_DATA) ||
                        (r_state == S_STOP);
    assign w_tick     = (r_state == S_START) ? (r_cnt == HALF_CNT)
                                             : (r_cnt == FULL_CNT);

    // Next-state logic and the per-sample actions.
    // NOTE: every signal driven here gets a default first, so no path can
    // leave a value held and infer a latch.
    always_comb begin
        w_next_state = r_state;
        w_shift_en   = 1'b0;
        w_load       = 1'b0;
        w_err        = 1'b0;
        case (r_state)
            S_WAIT_IDLE: begin
                if (w_rx_s) w_next_state = S_IDLE;
            end
            S_IDLE: begin
                if (!w_rx_s) w_next_state = S_START;
            end
            S_START: begin
                // A line that is high again at mid start bit is a glitch.
                if (w_tick) w_next_state = w_rx_s ? S_IDLE : S_DATA;
            end
            S_DATA: begin
                if (w_tick) begin
                    w_shift_en = 1'b1;
                    if (r_bit_idx == 3'd7) w_next_state = S_STOP;
                end
            end
            S_STOP: begin
                // Leaving at mid stop bit leaves half a bit to catch the
                // next start edge when frames arrive back to back.
                if (w_tick) begin
                    if (w_rx_s) begin
                        w_load       = 1'b1;
                        w_next_state = S_IDLE;
                    end else begin
                        w_err        = 1'b1;
                        w_next_state = S_WAIT_IDLE;
                    end
                end
            end
            default: w_next_state = S_WAIT_IDLE;
        endcase
    end

    // State register.
    // NOTE: reset is synchronous. Every register here is a small control or
    // data flop, so every one of them gets an explicit reset value.
    always_ff @(posedge clk) begin
        if (rst) r_state <= S_WAIT_IDLE;
        else     r_state <= w_next_state;
    end

    // Baud counter. It clears on any state change and at each sample point.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (!w_counting || w_tick || (w_next_state != r_state)) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    // Bit index. It starts from zero on entry to DATA and advances per sample.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_bit_idx <= 3'd0;
        end else if ((r_state == S_START) && (w_next_state == S_DATA)) begin
            r_bit_idx <= 3'd0;
        end else if (w_shift_en) begin
            r_bit_idx <= r_bit_idx + 3'd1;
        end
    end

    // Shift register. It fills from the MSB, so the first bit received ends in bit 0.
    always_ff @(posedge clk) begin
        if (rst)             r_shift <= 8'h00;
        else if (w_shift_en) r_shift <= {w_rx_s, r_shift[7:1]};
    end

    // Output byte and strobes. The byte is only updated on a good stop bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rx_data   <= 8'h00;
            r_rx_done   <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            if (w_load) r_rx_data <= r_shift;
            r_rx_done   <= w_load;
            r_frame_err <= w_err;
        end
    end

    assign rx_data   = r_rx_data;
    assign rx_done   = r_rx_done;
    assign frame_err = r_frame_err;
    assign busy      = w_counting;

endmodule

// File: doc/uart_rx_byte.md
# uart_rx_byte

Receives 8N1 asynchronous serial frames on a single input line and presents each good byte with a one-cycle `rx_done` strobe. It is the upstream stage of the debug activity indicator: `rx_done` drives that block's `rx_done` input directly. It also feeds any byte consumer on the debug path through `rx_data`.

## Interface
- `CLK_FREQ`, 100_000_000: system clock frequency in Hz.
- `BAUD`, 115200: line rate in bit/s.
- Derived `CLKS_PER_BIT = CLK_FREQ / BAUD`: integer division, truncated; 868 at the default values.
- Derived `HALF = (CLKS_PER_BIT - 1) / 2`: truncated; 433 at the default values.
- Elaboration fails if `CLKS_PER_BIT < 4`.
- `clk` input 1: system clock. All logic is on its rising edge.
- `rst` input 1: synchronous, active-high reset.
- `rx` input 1: asynchronous serial line. Idle is high.
- `rx_data` output 8: last correctly framed byte. Bit 0 is the first data bit received.
- `rx_done` output 1: one-cycle pulse when a good byte has been loaded into `rx_data`.
- `frame_err` output 1: one-cycle pulse when the stop bit is sampled low.
- `busy` output 1: high in START, DATA and STOP.

## Operation
- **Synchronizer**
  - `rx` passes through 2 flops to produce `rx_s`. Both flops reset to 1.
  - All decisions use `rx_s` only.
- **Baud counter**
  - Width is `$clog2(CLKS_PER_BIT)`. It clears on every state change.
  - Terminal value is `HALF` in START and `CLKS_PER_BIT-1` in DATA and STOP.
  - On reaching terminal, the counter clears and a sample event occurs.
- **States**
  - **WAIT_IDLE** (reset state): go to IDLE on the first cycle with `rx_s==1`.
  - **IDLE**: go to START on a cycle with `rx_s==0`.
  - **START**: at the sample event, if `rx_s==0` go to DATA with `bit_idx=0`. If `rx_s==1`, treat it as a glitch and go to IDLE with no output.
  - **DATA**: at each sample event, shift `rx_s` into the MSB of the shift register, shifting right, so bits arrive LSB-first. Increment `bit_idx` (3 bits). After the sample with `bit_idx==7`, go to STOP.
  - **STOP**: at the sample event:
    - If `rx_s==1`: load `rx_data` from the shift register, pulse `rx_done`, go to IDLE.
    - If `rx_s==0`: pulse `frame_err`, leave `rx_data` unchanged, go to WAIT_IDLE. This covers break conditions, so no frame restarts while the line is held low.
- **Strobes**: `rx_done` and `frame_err` are registered. They are never high together and never high for more than 1 cycle.
- **Reset**
  - Effective at any point, including mid-frame.
  - `rx_data=0`, `rx_done=0`, `frame_err=0`, `busy=0`, counter=0, `bit_idx=0`, shift register=0, state=WAIT_IDLE.
  - A partially received byte is discarded. No strobe is emitted for it.
- **Not supported**: parity, 2 stop bits, and rx FIFO buffering. The consumer must take `rx_data` before the next `rx_done`. `rx_data` is stable until then.

## Timing
- `rx_s` lags `rx` by 2 cycles.
- Let T0 be the cycle in which IDLE sees `rx_s==0`. START is entered at T0+1.
- Sample events:
  - Start bit at T0+1+HALF.
  - Data bit n at T0+1+HALF+(n+1)·CLKS_PER_BIT, for n = 0..7.
  - Stop bit at T0+1+HALF+9·CLKS_PER_BIT.
- `rx_done` or `frame_err` is high in the cycle after the stop sample edge. `rx_data` is valid in that same cycle.
- `busy` rises at T0+1 and falls together with the strobe.
- IDLE is re-entered mid-stop-bit, so the next start edge is caught with no lost frame at full back-to-back rate.
- Baud error tolerance is about ±4% given centre sampling.

## Test plan
Benches use `CLK_FREQ=1_000_000`, `BAUD=100_000`, giving `CLKS_PER_BIT=10` and `HALF=4`.
- Single frame 0xA5 with a good stop bit -> exactly one `rx_done` pulse, `rx_data==8'hA5`, `frame_err` stays 0, strobe cycle matches the T0 formula.
- Back-to-back 0x00 then 0xFF with no idle gap -> two `rx_done` pulses 100 cycles apart, data 0x00 then 0xFF.
- Line low for 3 cycles then high -> START aborts to IDLE. No `rx_done`, no `frame_err`, `rx_data` unchanged. A valid 0x3C afterwards is received correctly.
- Frame 0x55 with stop bit low, then line held low for 300 cycles -> one `frame_err` pulse, no `rx_done`, `rx_data` keeps its prior value, `busy` stays 0 until the line goes high. The next frame 0x81 is received.
- `rst` high for 1 cycle during data bit 4 of 0x96 -> all outputs 0 next cycle, no strobe for that frame. The following 0x69 is received once the line is idle.
